// File: rtl/digital_crown_encoder_if.sv
// rtl/digital_crown_encoder_if.sv - crown contact inputs and crown value/strobe outputs
interface digital_crown_encoder_if;
    logic       En;
    logic       clear;
    logic       crown_a;
    logic       crown_b;
    logic [9:0] DigitalCrownValue;
    logic       step_pulse;
    logic       step_dir;
    logic       err_pulse;

    modport master (
        output En, clear, crown_a, crown_b,
        input  DigitalCrownValue, step_pulse, step_dir, err_pulse
    );

    modport slave (
        input  En, clear, crown_a, crown_b,
        output DigitalCrownValue, step_pulse, step_dir, err_pulse
    );
endinterface

// File: rtl/digital_crown_encoder.sv
// rtl/digital_crown_encoder.sv - sync, debounce and quadrature-decode the crown into a 10-bit value
module digital_crown_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP            = 16,
    parameter int WRAP            = 1,
    parameter int RESET_VALUE     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    digital_crown_encoder_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]        RST_V   = 10'(RESET_VALUE);
    localparam logic [9:0]        STEP_V  = 10'(STEP);
    localparam logic signed [2:0] ACC_MAX = 3'sd3;
    localparam logic signed [2:0] ACC_MIN = -3'sd3;

    logic          r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic          r_a_db, r_b_db;
    logic [CW-1:0] r_a_cnt, r_b_cnt;
    logic [1:0]    r_prev;
    logic signed [2:0] r_acc;
    logic [9:0]    r_value;
    logic          r_step_pulse, r_step_dir, r_err_pulse;

    logic [1:0]    w_cur;
    logic          w_cw, w_ccw, w_illegal;
    logic [10:0]   w_up_sum;
    logic [9:0]    w_up_val, w_dn_val;
    logic signed [2:0] w_acc_nxt;
    logic [9:0]    w_value_nxt;
    logic          w_step_nxt, w_dir_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_s1 <= 1'b0;
            r_a_s2 <= 1'b0;
            r_b_s1 <= 1'b0;
            r_b_s2 <= 1'b0;
        end else begin
            r_a_s1 <= bus.crown_a;
            r_a_s2 <= r_a_s1;
            r_b_s1 <= bus.crown_b;
            r_b_s2 <= r_b_s1;
        end
    end

    // A channel is accepted only after differing for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_db  <= 1'b0;
            r_a_cnt <= '0;
        end else if (r_a_s2 == r_a_db) begin
            r_a_cnt <= '0;
        end else if (r_a_cnt == CNT_MAX) begin
            r_a_db  <= r_a_s2;
            r_a_cnt <= '0;
        end else begin
            r_a_cnt <= r_a_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_db  <= 1'b0;
            r_b_cnt <= '0;
        end else if (r_b_s2 == r_b_db) begin
            r_b_cnt <= '0;
        end else if (r_b_cnt == CNT_MAX) begin
            r_b_db  <= r_b_s2;
            r_b_cnt <= '0;
        end else begin
            r_b_cnt <= r_b_cnt + 1'b1;
        end
    end

    assign w_cur     = {r_a_db, r_b_db};
    assign w_cw      = (r_prev == 2'b00 && w_cur == 2'b01) || (r_prev == 2'b01 && w_cur == 2'b11) ||
                       (r_prev == 2'b11 && w_cur == 2'b10) || (r_prev == 2'b10 && w_cur == 2'b00);
    assign w_ccw     = (r_prev == 2'b01 && w_cur == 2'b00) || (r_prev == 2'b11 && w_cur == 2'b01) ||
                       (r_prev == 2'b10 && w_cur == 2'b11) || (r_prev == 2'b00 && w_cur == 2'b10);
    assign w_illegal = (r_prev ^ w_cur) == 2'b11;

    assign w_up_sum = {1'b0, r_value} + {1'b0, STEP_V};
    assign w_up_val = (WRAP != 0) ? w_up_sum[9:0] : (w_up_sum[10] ? 10'h3FF : w_up_sum[9:0]);
    assign w_dn_val = (WRAP != 0 || r_value >= STEP_V) ? (r_value - STEP_V) : 10'd0;

    // The accumulator never holds +-4: the fourth quarter steps the value and clears it instead.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_value_nxt = r_value;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = r_step_dir;
        if (bus.clear) begin
            w_acc_nxt   = '0;
            w_value_nxt = RST_V;
        end else if (!bus.En) begin
            w_acc_nxt = '0;
        end else if (w_cw) begin
            if (r_acc == ACC_MAX) begin
                w_acc_nxt   = '0;
                w_value_nxt = w_up_val;
                w_step_nxt  = 1'b1;
                w_dir_nxt   = 1'b1;
            end else begin
                w_acc_nxt = r_acc + 3'sd1;
            end
        end else if (w_ccw) begin
            if (r_acc == ACC_MIN) begin
                w_acc_nxt   = '0;
                w_value_nxt = w_dn_val;
                w_step_nxt  = 1'b1;
                w_dir_nxt   = 1'b0;
            end else begin
                w_acc_nxt = r_acc - 3'sd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= 2'b00;
            r_acc        <= '0;
            r_value      <= RST_V;
            r_step_pulse <= 1'b0;
            r_step_dir   <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_prev       <= w_cur;
            r_acc        <= w_acc_nxt;
            r_value      <= w_value_nxt;
            r_step_pulse <= w_step_nxt;
            r_step_dir   <= w_dir_nxt;
            r_err_pulse  <= w_illegal;
        end
    end

    assign bus.DigitalCrownValue = r_value;
    assign bus.step_pulse        = r_step_pulse;
    assign bus.step_dir          = r_step_dir;
    assign bus.err_pulse         = r_err_pulse;
endmodule

// File: tb/tb_digital_crown_encoder.sv
// tb/tb_digital_crown_encoder.sv - randomized quadrature stimulus against a detent-level model, wrap and saturate variants
module tb_digital_crown_encoder;
    logic clk = 1'b0;
    logic rst;
    logic en, clr, raw_a, raw_b;

    digital_crown_encoder_if if_w ();
    digital_crown_encoder_if if_s ();

    assign if_w.En = en;
    assign if_w.clear = clr;
    assign if_w.crown_a = raw_a;
    assign if_w.crown_b = raw_b;
    assign if_s.En = en;
    assign if_s.clear = clr;
    assign if_s.crown_a = raw_a;
    assign if_s.crown_b = raw_b;

    digital_crown_encoder #(.DEBOUNCE_CYCLES(4), .STEP(16), .WRAP(1), .RESET_VALUE(0))
        u_wrap (.clk(clk), .rst(rst), .bus(if_w.slave));
    digital_crown_encoder #(.DEBOUNCE_CYCLES(4), .STEP(16), .WRAP(0), .RESET_VALUE(0))
        u_sat (.clk(clk), .rst(rst), .bus(if_s.slave));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cnt_step_w = 0, cnt_step_s = 0, cnt_err = 0;

    // Reference model: gray position, quarter count, detent-level values.
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int pos = 0;
    int quarters = 0;
    int vw = 0, vs = 0;
    int exp_steps = 0, exp_err = 0, exp_dir = 0;

    always @(negedge clk) begin
        if (if_w.step_pulse) cnt_step_w <= cnt_step_w + 1;
        if (if_s.step_pulse) cnt_step_s <= cnt_step_s + 1;
        if (if_w.err_pulse)  cnt_err    <= cnt_err + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("value_wrap", int'(if_w.DigitalCrownValue), vw);
        check("value_sat", int'(if_s.DigitalCrownValue), vs);
        check("steps_wrap", cnt_step_w, exp_steps);
        check("steps_sat", cnt_step_s, exp_steps);
        check("errors", cnt_err, exp_err);
        check("step_dir", int'(if_w.step_dir), exp_dir);
    endtask

    function automatic void model_detent(input int up);
        exp_steps++;
        exp_dir = up;
        if (up != 0) begin
            vw = (vw + 16) % 1024;
            vs = (vs + 16 > 1023) ? 1023 : vs + 16;
        end else begin
            vw = (vw + 1024 - 16) % 1024;
            vs = (vs < 16) ? 0 : vs - 16;
        end
    endfunction

    // kind: 0 CW quarter, 1 CCW quarter, 2 illegal jump, 3 short glitch on A
    // mode: 0 plain, 1 check exact step latency, 2 clear on the step edge
    task automatic move(input int kind, input int mode);
        int np;
        np = pos;
        @(posedge clk); #1;
        if (kind == 3) begin
            raw_a = ~raw_a;
            repeat (3) @(posedge clk);
            #1 raw_a = ~raw_a;
        end else begin
            np = (kind == 0) ? (pos + 1) % 4 : (kind == 1) ? (pos + 3) % 4 : (pos + 2) % 4;
            {raw_a, raw_b} = gray[np];
        end
        if (mode == 1) begin
            repeat (6) @(posedge clk);
            #1 check("latency_early", int'(if_w.step_pulse), 0);
            @(posedge clk);
            #1 check("latency_hit", int'(if_w.step_pulse), 1);
        end else if (mode == 2) begin
            repeat (6) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
        end
        repeat (10) @(posedge clk);
        if (kind != 3) begin
            pos = np;
            if (kind == 2) begin
                exp_err++;
            end else if (mode == 2) begin
                quarters = 0;
                vw = 0;
                vs = 0;
            end else if (en == 1'b0) begin
                quarters = 0;
            end else begin
                quarters += (kind == 0) ? 1 : -1;
                if (quarters == 4 || quarters == -4) begin
                    model_detent(quarters == 4 ? 1 : 0);
                    quarters = 0;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        pos = 0; quarters = 0; vw = 0; vs = 0; exp_dir = 0;
    endtask

    initial begin
        int r;
        rst = 1'b1; en = 1'b1; clr = 1'b0; raw_a = 1'b0; raw_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        check("reset_pulse", int'(if_w.step_pulse), 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) move(0, 0);
        move(0, 1);
        move(3, 0);

        // Async reset mid-debounce, mid-cycle
        @(posedge clk); #1 {raw_a, raw_b} = gray[(pos + 1) % 4];
        repeat (3) @(posedge clk);
        #3 rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
        #1 check("async_reset_value", int'(if_w.DigitalCrownValue), 0);
        check("async_reset_pulse", int'(if_w.step_pulse), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_all();

        for (int i = 0; i < 3; i++) move(0, 0);
        for (int i = 0; i < 3; i++) move(1, 0);
        move(0, 0); move(0, 0); move(2, 0); move(0, 0); move(0, 0);

        en = 1'b0;
        for (int i = 0; i < 4; i++) move(0, 0);
        move(2, 0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) move(0, 0);
        move(0, 2);

        for (int k = 1; k <= 64; k++) begin
            for (int j = 0; j < 4; j++) move(0, 0);
            check("sweep_city", int'(if_w.DigitalCrownValue) / 128, ((k * 16) % 1024) / 128);
        end
        for (int j = 0; j < 4; j++) move(1, 0);
        clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
        quarters = 0; vw = 0; vs = 0;
        for (int j = 0; j < 4; j++) move(1, 0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 7));
            if (r <= 2)      move(0, 0);
            else if (r <= 4) move(1, 0);
            else if (r == 5) move(2, 0);
            else if (r == 6) move(3, 0);
            else begin
                en = ~en;
                if (en == 1'b0) quarters = 0;
                move(0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
